// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and default widths for the data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        CPU = 1'b0,
        PER = 1'b1
    } req_id_e;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == CPU) ? PER : CPU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin pick; on a tie the side not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last_grant,
    output req_id_e    grant
);

    // bit 0 is the CPU, bit 1 the peripheral
    always_comb begin
        grant = CPU;
        case (req)
            2'b01:   grant = CPU;
            2'b10:   grant = PER;
            2'b11:   grant = other_req(last_grant);
            default: grant = CPU;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares one single-port data memory between the CPU and a
//               peripheral/DMA port using a 3-cycle IDLE/ACCESS/DONE sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,

    input  logic              per_req,
    input  logic              per_we,
    input  logic [ADDR_W-1:0] per_addr,
    input  logic [DATA_W-1:0] per_wdata,
    output logic [DATA_W-1:0] per_rdata,
    output logic              per_ready,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e  r_state;
    req_id_e r_owner;
    req_id_e r_last_grant;
    req_id_e w_grant;
    logic    w_in_access;
    logic    w_in_done;

    rr_arbiter2 u_rr (
        .req        ({per_req, cpu_req}),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_owner      <= CPU;
            r_last_grant <= PER;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_req || per_req) begin
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS:  r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Qualifying with reset keeps every output at zero while reset is low,
    // independent of how the register reset propagates.
    assign w_in_access = reset && (r_state == ACCESS);
    assign w_in_done   = reset && (r_state == DONE);

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_in_access) begin
            if (r_owner == CPU) begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end else begin
                mem_we    = per_we;
                mem_addr  = per_addr;
                mem_wdata = per_wdata;
            end
        end
    end

    always_comb begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        per_ready = 1'b0;
        per_rdata = '0;
        if (w_in_done) begin
            if (r_owner == CPU) begin
                cpu_ready = 1'b1;
                cpu_rdata = mem_rdata;
            end else begin
                per_ready = 1'b1;
                per_rdata = mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Randomised self-checking bench with a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, per_req, per_we;
    logic [31:0] cpu_addr, cpu_wdata, per_addr, per_wdata;
    logic [31:0] cpu_rdata, per_rdata;
    logic        cpu_ready, per_ready;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_cmp;
    int n_bad;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .per_req   (per_req),
        .per_we    (per_we),
        .per_addr  (per_addr),
        .per_wdata (per_wdata),
        .per_rdata (per_rdata),
        .per_ready (per_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 8) ? 32'h0000_1234 : (32'h1000 + 32'(i) * 32'h11);
    endfunction

    // Memory environment: registered read, 16 words indexed by addr[5:2].
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[5:2]];
    end

    // Reference model: an access is a captured transaction with an age
    // (-1 none, 0 memory cycle, 1 completion cycle).
    int          m_age;
    logic        m_owner, m_last, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [31:0] shadow [16];

    function automatic logic pick(input logic c, input logic p, input logic last);
        if (c && p) return ~last;
        return c ? 1'b0 : 1'b1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_age   <= -1;
            m_last  <= 1'b1;
            m_owner <= 1'b0;
            for (int i = 0; i < 16; i++) shadow[i] <= init_word(i);
        end else if (m_age == -1) begin
            if (cpu_req || per_req) begin
                m_owner <= pick(cpu_req, per_req, m_last);
                m_last  <= pick(cpu_req, per_req, m_last);
                m_we    <= pick(cpu_req, per_req, m_last) ? per_we    : cpu_we;
                m_addr  <= pick(cpu_req, per_req, m_last) ? per_addr  : cpu_addr;
                m_wdata <= pick(cpu_req, per_req, m_last) ? per_wdata : cpu_wdata;
                m_age   <= 0;
            end
        end else if (m_age == 0) begin
            m_rdata <= shadow[m_addr[5:2]];
            if (m_we) shadow[m_addr[5:2]] <= m_wdata;
            m_age <= 1;
        end else begin
            m_age <= -1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_cmp();
        logic acc, dn;
        acc = (m_age == 0);
        dn  = (m_age == 1);
        chk("mem_we",    {31'b0, mem_we},    acc ? {31'b0, m_we} : 32'd0);
        chk("mem_addr",  mem_addr,           acc ? m_addr  : 32'd0);
        chk("mem_wdata", mem_wdata,          acc ? m_wdata : 32'd0);
        chk("cpu_ready", {31'b0, cpu_ready}, {31'b0, dn && !m_owner});
        chk("per_ready", {31'b0, per_ready}, {31'b0, dn &&  m_owner});
        chk("cpu_rdata", cpu_rdata,          (dn && !m_owner) ? m_rdata : 32'd0);
        chk("per_rdata", per_rdata,          (dn &&  m_owner) ? m_rdata : 32'd0);
    endtask

    task automatic step();
        @(negedge clk);
        model_cmp();
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        cpu_req = 1'b0;
        per_req = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic set_cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_per(input logic we, input logic [31:0] a, input logic [31:0] d);
        per_req = 1'b1; per_we = we; per_addr = a; per_wdata = d;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        per_req = 1'b0; per_we = 1'b0; per_addr = '0; per_wdata = '0;

        // Outputs held at zero during reset
        step();
        step();
        chk("rst_mem_we",    {31'b0, mem_we},    32'd0);
        chk("rst_mem_addr",  mem_addr,           32'd0);
        chk("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        chk("rst_per_rdata", per_rdata,          32'd0);
        reset = 1'b1;

        // CPU write 7 to address 100
        set_cpu(1'b1, 32'd100, 32'd7);
        step();
        chk("w_mem_we",    {31'b0, mem_we},    32'd1);
        chk("w_mem_addr",  mem_addr,           32'd100);
        chk("w_mem_wdata", mem_wdata,          32'd7);
        chk("w_cpu_ready0", {31'b0, cpu_ready}, 32'd0);
        step();
        chk("w_mem_we_off", {31'b0, mem_we},    32'd0);
        chk("w_cpu_ready",  {31'b0, cpu_ready}, 32'd1);
        chk("w_per_ready",  {31'b0, per_ready}, 32'd0);
        cpu_req = 1'b0;
        step();
        chk("w_cpu_ready_end", {31'b0, cpu_ready}, 32'd0);

        // PER read from address 96 (preloaded with 0x1234)
        set_per(1'b0, 32'd96, 32'hDEAD_BEEF);
        step();
        chk("r_mem_we",   {31'b0, mem_we}, 32'd0);
        chk("r_mem_addr", mem_addr,        32'd96);
        step();
        chk("r_per_ready", {31'b0, per_ready}, 32'd1);
        chk("r_per_rdata", per_rdata,          32'h0000_1234);
        chk("r_mem_we2",   {31'b0, mem_we},    32'd0);
        chk("r_cpu_rdata", cpu_rdata,          32'd0);
        per_req = 1'b0;
        step();

        // Simultaneous request after reset: CPU at +2, PER at +5
        do_reset();
        set_cpu(1'b0, 32'h10, 32'd0);
        set_per(1'b0, 32'h20, 32'd0);
        for (int n = 1; n <= 5; n++) begin
            step();
            chk("dual_cpu_ready", {31'b0, cpu_ready}, {31'b0, n == 2});
            chk("dual_per_ready", {31'b0, per_ready}, {31'b0, n == 5});
            if (n == 2) begin
                chk("dual_cpu_rdata", cpu_rdata, 32'h0000_1044);
                cpu_req = 1'b0;
            end
            if (n == 5) begin
                chk("dual_per_rdata", per_rdata, 32'h0000_1234);
                per_req = 1'b0;
            end
        end
        step();

        // Continuous dual requests alternate CPU, PER, ... every 3 cycles
        do_reset();
        set_cpu(1'b1, 32'h40, 32'hAAAA_0001);
        set_per(1'b1, 32'h44, 32'hBBBB_0002);
        for (int n = 1; n <= 18; n++) begin
            step();
            chk("alt_cpu_ready", {31'b0, cpu_ready}, {31'b0, (n % 6) == 2});
            chk("alt_per_ready", {31'b0, per_ready}, {31'b0, (n % 6) == 5});
        end
        cpu_req = 1'b0;
        per_req = 1'b0;
        step();
        step();

        // Reset during the memory cycle of a CPU write aborts it
        set_cpu(1'b1, 32'd100, 32'd7);
        step();
        chk("abort_mem_we_pre", {31'b0, mem_we}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_mem_we_async", {31'b0, mem_we}, 32'd0);
        chk("abort_mem_addr",     mem_addr,        32'd0);
        step();
        chk("abort_cpu_ready", {31'b0, cpu_ready}, 32'd0);
        cpu_req = 1'b0;
        step();
        reset = 1'b1;
        set_cpu(1'b0, 32'd100, 32'd0);
        set_per(1'b0, 32'd96, 32'd0);
        step();
        step();
        chk("post_abort_cpu_wins", {31'b0, cpu_ready}, 32'd1);
        chk("post_abort_per_idle", {31'b0, per_ready}, 32'd0);
        chk("post_abort_rdata",    cpu_rdata,          32'h0000_1099);
        cpu_req = 1'b0;
        per_req = 1'b0;
        step();

        // Randomised traffic, including occasional asynchronous resets
        for (int c = 0; c < 2000; c++) begin
            step();
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(0, 249) == 0) begin
                reset = 1'b0;
            end
            if (cpu_req) begin
                if (cpu_ready) begin
                    if ($urandom_range(0, 3) == 0)
                        set_cpu(1'($urandom_range(0, 1)), $urandom(), $urandom());
                    else
                        cpu_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                set_cpu(1'($urandom_range(0, 1)), $urandom(), $urandom());
            end
            if (per_req) begin
                if (per_ready) begin
                    if ($urandom_range(0, 3) == 0)
                        set_per(1'($urandom_range(0, 1)), $urandom(), $urandom());
                    else
                        per_req = 1'b0;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                set_per(1'($urandom_range(0, 1)), $urandom(), $urandom());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, meaning: width of requester and memory byte addresses.
REQ-002 Parameter DATA_W, default 32, meaning: width of read and write data.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 cpu_req  input  1  CPU data-port access request, held until cpu_ready.
REQ-006 cpu_we  input  1  CPU access is a write (1) or a read (0).
REQ-007 cpu_addr  input  ADDR_W  CPU byte address.
REQ-008 cpu_wdata  input  DATA_W  CPU write data.
REQ-009 cpu_rdata  output  DATA_W  CPU read data, valid while cpu_ready=1.
REQ-010 cpu_ready  output  1  one-cycle completion pulse for the CPU access.
REQ-011 per_req, per_we, per_addr, per_wdata, per_rdata, per_ready  same directions, widths and meanings as the CPU port, for the second requester (peripheral/DMA).
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_addr  output  ADDR_W  memory byte address.
REQ-014 mem_wdata  output  DATA_W  memory write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, registered by the memory one cycle after mem_addr is presented.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCESS, DONE.
REQ-017 IDLE: if any req=1 at the rising edge, the FSM SHALL latch the winner into owner and move to ACCESS; otherwise it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: a single requester wins outright; if both request, the requester not equal to last_grant wins.
REQ-019 last_grant SHALL update to owner on the IDLE->ACCESS transition.
REQ-020 ACCESS (exactly one cycle): mem_addr, mem_wdata and mem_we SHALL be driven combinationally from the owner's addr, wdata and we; the next state SHALL be DONE.
REQ-021 Outside ACCESS: mem_we SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-022 DONE (exactly one cycle): the owner's ready SHALL be 1 and its rdata SHALL equal mem_rdata; the next state SHALL be IDLE.
REQ-023 The non-owner's ready SHALL be 0 and its rdata SHALL be 0 in every state.
REQ-024 Latency SHALL be ready two cycles after the edge at which the request wins; minimum access period is 3 cycles.
REQ-025 Requesters SHALL hold req, we, addr and wdata stable until ready; the arbiter SHALL not re-sample them except in ACCESS.
REQ-026 req values seen in ACCESS and DONE SHALL be ignored; a losing or newly raised request SHALL be arbitrated on the next IDLE edge.
REQ-027 A requester that keeps req high after ready SHALL be treated as a new access.
REQ-028 Under continuous dual requests, grants SHALL strictly alternate, so neither side waits more than one access (3 cycles).
REQ-029 Exactly one memory write SHALL occur per write access, and none for reads.

Reset
REQ-030 While reset=0, the arbiter SHALL force state=IDLE, owner=CPU, last_grant=PER, asynchronously.
REQ-031 While reset=0, all outputs SHALL be 0: mem_we, mem_addr, mem_wdata, cpu_ready, per_ready, cpu_rdata, per_rdata.
REQ-032 Reset asserted during ACCESS SHALL drop mem_we immediately; the interrupted access SHALL not complete and no ready SHALL be issued.
REQ-033 After reset deassertion, the CPU SHALL win the first simultaneous request.

Structure
REQ-034 Package dmem_arb_pkg SHALL hold the state enum {IDLE, ACCESS, DONE}, the requester enum {CPU, PER}, and the default width constants.
REQ-035 The 2-way round-robin pick SHALL be a separate sub-module rr_arbiter2 (inputs: req[1:0], last_grant; output: grant id); the FSM and muxing stay in dmem_arbiter.

Verification
REQ-036 CPU write only, cpu_addr=100, cpu_wdata=7 -> mem_we=1 with mem_addr=100 and mem_wdata=7 for exactly one cycle; cpu_ready pulses 1 cycle later; per_ready stays 0.
REQ-037 PER read only, per_addr=96, with the memory model returning 0x1234 -> per_ready=1 and per_rdata=0x1234 in DONE; mem_we stays 0 throughout.
REQ-038 Both requesters raise req in the same cycle after reset -> CPU is served first (ready at +2), PER is granted on the next IDLE edge (ready at +5).
REQ-039 Both requesters hold req continuously for 6 accesses -> grant order CPU, PER, CPU, PER, CPU, PER; each ready is 3 cycles apart.
REQ-040 reset driven to 0 mid-ACCESS of a CPU write to address 100 -> mem_we falls without a clock edge, no cpu_ready, state IDLE; the next dual request goes to the CPU.
